uart_rx: RTL and testbench
==========================

# uart_rx

UART serial receiver with 16x oversampling. Consumes the 16x sample tick from the baud generator, recovers 8N1 frames (optional parity) from the asynchronous `rxd` line, and presents each byte on a valid/ready holding register. Sits between the pad-side `rxd` input and the host-side byte consumer, opposite the UART transmitter.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first.
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `samp_tick`  in  1  one-`clk` pulse at 16x baud; all bit timing counts these pulses.
- `rxd`  in  1  serial line, asynchronous, idle high.
- `rx_data`  out  DATA_BITS  received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts on `rx_valid && rx_ready`.
- `frame_err`  out  1  stop bit sampled low; qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`; 0 when `PARITY_EN`=0.
- `overrun`  out  1  one-`clk` pulse when a completed frame is dropped.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1), giving `rxd_s`. All decisions use `rxd_s` and are evaluated only on `samp_tick` cycles.
- 4-bit tick counter `cnt`, bit index counter, and shift register.
- States:
  - IDLE: `cnt`=0. On `samp_tick` with `rxd_s`=0, go to START.
  - START: `cnt`++ per tick. At the 8th tick (`cnt`==7, mid start bit), `rxd_s`=0 → DATA with `cnt`=0. `rxd_s`=1 → false start, return to IDLE.
  - DATA: at `cnt`==15, shift `rxd_s` in at the MSB and right-shift, so data is LSB first. Then `cnt`=0 and the bit index increments. After `DATA_BITS` bits go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: sample at `cnt`==15. Compare against the XOR of the data bits, XORed with `PARITY_ODD`.
  - STOP: sample at `cnt`==15, then deliver.
    - `rxd_s`=1 → IDLE.
    - `rxd_s`=0 → set `frame_err` and go to BRK_WAIT.
  - BRK_WAIT: stay until a `samp_tick` with `rxd_s`=1, then IDLE. This prevents a break from producing repeated frames.
- Delivery, on the STOP sample tick:
  - `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data`, `frame_err`, `parity_err` and set `rx_valid`=1.
  - `rx_valid`=1 and `rx_ready`=0: drop the new frame, keep the old data and flags, pulse `overrun`.
- `rx_valid` clears the cycle after an accept, unless a new frame loads in that same cycle.
- Frames with errors are still delivered, with their flags set.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state IDLE, synchronizer flops=1.
- Reset asserted mid-frame returns to IDLE immediately and discards the partial frame.
- Start detection is delayed 2 `clk` by the synchronizer plus up to 1 tick of quantization.
- `rx_valid` rises 1 `clk` after the `samp_tick` that samples the stop bit. That is (8 + 16·(DATA_BITS+PARITY_EN+1)) ticks after start detection: 152 ticks for 8N1.
- The receiver returns to IDLE half a bit early. The next start bit can be detected immediately, so back-to-back frames are supported.
- Bit period must equal 16 `samp_tick` periods, ±3% accumulated over the frame.
- A `samp_tick` wider than 1 `clk` is illegal. Every `samp_tick`-high cycle counts as one tick.

## Structure
- `uart_pkg`:
  - `rx_state_e` enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - `OVERSAMPLE`=16, `MID_SAMPLE`=7, `LAST_SAMPLE`=15.
- One sub-module, `uart_sync`: 2-flop synchronizer with parameterized reset value, reused for other async inputs.
- All other logic (FSM, counters, shift register, holding register) lives in `uart_rx`.

## Test plan
- 8N1, one tick every 6 `clk`, bit = 96 `clk`, send 0x55 → one `rx_valid` with `rx_data`=0x55, `frame_err`=0, `parity_err`=0, 152 ticks after start.
- `rxd` low for 4 ticks then high → no `rx_valid`; FSM back in IDLE and the next frame 0x3C is received correctly.
- Send 0xA3 with stop bit low → `rx_data`=0xA3, `frame_err`=1. `rxd` held low a further 40 ticks → no extra `rx_valid`.
- `PARITY_EN`=1, even parity, send 0x07 with parity bit 0 → `parity_err`=1. The same frame with parity bit 1 → `parity_err`=0.
- `rx_ready`=0, back-to-back 0x12, 0x34 → `rx_data` stays 0x12 and `overrun` pulses exactly once. Then `rx_ready`=1 → accept, and `rx_valid` drops next cycle.
- Assert `rst_n` during DATA bit 3 of 0xC4 → outputs go to reset values at once. Release, resend 0xC4 → `rx_data`=0xC4, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding and oversampling points.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned CNT_W       = $clog2(OVERSAMPLE);
  localparam int unsigned MID_SAMPLE  = 7;
  localparam int unsigned LAST_SAMPLE = 15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs with a configurable reset level.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver with optional parity and a valid/ready byte holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 samp_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  logic                 rxd_s;
  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt, pe_nxt, ovr_nxt;
  logic                 deliver, last;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Frame sequencing and holding-register update; every decision waits for samp_tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    perr_nxt  = perr;
    data_nxt  = rx_data;
    valid_nxt = rx_valid && !rx_ready;
    ferr_nxt  = frame_err;
    pe_nxt    = parity_err;
    ovr_nxt   = 1'b0;
    deliver   = 1'b0;
    last      = (cnt == CNT_W'(LAST_SAMPLE));

    if (samp_tick) begin
      unique case (state)
        IDLE: begin
          cnt_nxt  = '0;
          idx_nxt  = '0;
          perr_nxt = 1'b0;
          if (!rxd_s) state_nxt = START;
        end
        START: begin
          if (cnt == CNT_W'(MID_SAMPLE)) begin
            cnt_nxt   = '0;
            state_nxt = rxd_s ? IDLE : DATA;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (last) begin
            shreg_nxt = {rxd_s, shreg[DATA_BITS-1:1]};
            cnt_nxt   = '0;
            if (idx == IDX_W'(DATA_BITS - 1)) begin
              idx_nxt   = '0;
              state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (last) begin
            perr_nxt  = rxd_s ^ (^shreg) ^ (PARITY_ODD != 0);
            cnt_nxt   = '0;
            state_nxt = STOP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (last) begin
            cnt_nxt   = '0;
            deliver   = 1'b1;
            state_nxt = rxd_s ? IDLE : BRK_WAIT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        BRK_WAIT: begin
          if (rxd_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // A full, unaccepted holding register drops the new frame instead of overwriting it.
    if (deliver) begin
      if (!rx_valid || rx_ready) begin
        data_nxt  = shreg;
        valid_nxt = 1'b1;
        ferr_nxt  = !rxd_s;
        pe_nxt    = perr;
      end else begin
        ovr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      perr       <= perr_nxt;
      rx_data    <= data_nxt;
      rx_valid   <= valid_nxt;
      frame_err  <= ferr_nxt;
      parity_err <= pe_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 receiver plus an even-parity instance on the same serial line.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       samp_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       ready_p = 1'b0;
  logic [7:0] rx_data, data_p;
  logic       rx_valid, valid_p;
  logic       frame_err, ferr_p;
  logic       parity_err, perr_p;
  logic       overrun, ovr_p;

  int n_assert = 0;
  int n_fail = 0;
  int tick_total = 0;
  int rises = 0;
  int rise_tick = 0;
  int ovr_cnt = 0;
  int t0 = 0;
  int r0, o0;
  logic       valid_prev = 1'b0;
  logic [2:0] div = 3'd0;
  logic [31:0] v;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .samp_tick  (samp_tick),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .samp_tick  (samp_tick),
    .rxd        (rxd),
    .rx_data    (data_p),
    .rx_valid   (valid_p),
    .rx_ready   (ready_p),
    .frame_err  (ferr_p),
    .parity_err (perr_p),
    .overrun    (ovr_p)
  );

  always #5 clk = ~clk;

  // One tick every 6 clk, so one bit is 96 clk.
  always @(posedge clk) begin
    if (div == 3'd5) begin
      div       <= 3'd0;
      samp_tick <= 1'b1;
    end else begin
      div       <= div + 3'd1;
      samp_tick <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (samp_tick) tick_total++;
    if (rx_valid && !valid_prev) begin
      rises++;
      rise_tick = tick_total;
    end
    valid_prev = rx_valid;
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Send n line bits LSB first, starting right after a tick edge.
  task automatic send_bits(input logic [31:0] bits, input int n);
    @(negedge clk);
    for (int k = 0; k < 12 && samp_tick !== 1'b1; k++) @(negedge clk);
    @(posedge clk);
    #1;
    t0 = tick_total;
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (96) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int nclk);
    rxd = 1'b1;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit par_dut);
    @(posedge clk);
    #1;
    if (par_dut) ready_p = 1'b1; else rx_ready = 1'b1;
    @(posedge clk);
    #1;
    ready_p  = 1'b0;
    rx_ready = 1'b0;
  endtask

  function automatic logic [31:0] fr(input logic [7:0] d, input logic stop);
    return {22'd0, stop, d, 1'b0};
  endfunction

  function automatic logic [31:0] frp(input logic [7:0] d, input logic p);
    return {21'd0, 1'b1, p, d, 1'b0};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle(200);

    // 0x55; latency counts the detection tick plus 152 more.
    r0 = rises;
    send_bits(fr(8'h55, 1'b1), 10);
    check("55_valid", 32'(rx_valid), 32'd1);
    check("55_data", 32'(rx_data), 32'h55);
    check("55_ferr", 32'(frame_err), 32'd0);
    check("55_perr", 32'(parity_err), 32'd0);
    check("55_latency", 32'(rise_tick - t0), 32'd153);
    check("55_rises", 32'(rises - r0), 32'd1);
    accept(1'b0);
    check("55_accepted", 32'(rx_valid), 32'd0);
    idle(200);

    // False start: 4 ticks low, then a real frame.
    r0 = rises;
    rxd = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    idle(600);
    check("false_start_none", 32'(rises - r0), 32'd0);
    send_bits(fr(8'h3C, 1'b1), 10);
    check("3c_valid", 32'(rx_valid), 32'd1);
    check("3c_data", 32'(rx_data), 32'h3C);
    check("3c_ferr", 32'(frame_err), 32'd0);
    accept(1'b0);
    idle(200);

    // Low stop bit, then a break of 40 more ticks.
    r0 = rises;
    send_bits(fr(8'hA3, 1'b0), 10);
    check("a3_valid", 32'(rx_valid), 32'd1);
    check("a3_data", 32'(rx_data), 32'hA3);
    check("a3_ferr", 32'(frame_err), 32'd1);
    check("a3_perr", 32'(parity_err), 32'd0);
    rxd = 1'b0;
    accept(1'b0);
    repeat (238) @(posedge clk);
    #1;
    idle(1200);
    check("break_rises", 32'(rises - r0), 32'd1);
    check("break_valid", 32'(rx_valid), 32'd0);

    // Even parity on the parity instance: 0x07 has odd weight, so parity bit must be 1.
    accept(1'b1);
    idle(200);
    send_bits(frp(8'h07, 1'b0), 11);
    check("p0_valid", 32'(valid_p), 32'd1);
    check("p0_data", 32'(data_p), 32'h07);
    check("p0_perr", 32'(perr_p), 32'd1);
    check("p0_ferr", 32'(ferr_p), 32'd0);
    accept(1'b1);
    idle(200);
    send_bits(frp(8'h07, 1'b1), 11);
    check("p1_valid", 32'(valid_p), 32'd1);
    check("p1_data", 32'(data_p), 32'h07);
    check("p1_perr", 32'(perr_p), 32'd0);
    accept(1'b1);
    accept(1'b0);
    idle(300);

    // Back-to-back frames with no consumer: second frame is dropped.
    accept(1'b0);
    o0 = ovr_cnt;
    v = (fr(8'h34, 1'b1) << 10) | fr(8'h12, 1'b1);
    send_bits(v, 20);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h12);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    check("ovr_pre_accept", 32'(rx_valid), 32'd1);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("ovr_post_accept", 32'(rx_valid), 32'd0);
    idle(200);

    // Fill the holding register, then reset in the middle of data bit 3.
    send_bits(fr(8'h81, 1'b0), 10);
    idle(200);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    check("pre_rst_ferr", 32'(frame_err), 32'd1);
    send_bits(fr(8'hC4, 1'b1), 4);
    rxd = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_perr", 32'(parity_err), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(200);
    send_bits(fr(8'hC4, 1'b1), 10);
    check("c4_valid", 32'(rx_valid), 32'd1);
    check("c4_data", 32'(rx_data), 32'hC4);
    check("c4_ferr", 32'(frame_err), 32'd0);
    check("c4_perr", 32'(parity_err), 32'd0);
    accept(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
